// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers. They work on any width up to MAX_W
// as long as the value is zero-extended, because the unused upper bits then stay zero.
package gray_pkg;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/bin_to_gray_n.sv
// Combinational binary-to-Gray encoder of WIDTH bits.
module bin_to_gray_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(MAX_W'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with a variable step, a load input and a wrap pulse.
// Defining GRAY_LOAD_EN makes load_val a Gray-coded value that is decoded before loading.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP_MAX = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             up_dn,
  input  logic [$clog2(STEP_MAX+1)-1:0]    step,
  input  logic                             load,
  input  logic [WIDTH-1:0]                 load_val,
  output logic [WIDTH-1:0]                 gray,
  output logic [WIDTH-1:0]                 bin,
  output logic                             wrap
);

  localparam int SW = $clog2(STEP_MAX+1);
  localparam logic [SW-1:0] SMAX = SW'(STEP_MAX);

  logic [WIDTH-1:0] bin_q, gray_q, bin_nxt, gray_nxt, load_bin;
  logic             wrap_q, wrap_nxt;
  logic [SW-1:0]    step_sat;
  logic [WIDTH:0]   step_ext, sum;

  assign step_sat = (step > SMAX) ? SMAX : step;
  assign step_ext = (WIDTH+1)'(step_sat);
  // The extra MSB carries out on an up-wrap and borrows on a down-wrap.
  assign sum      = up_dn ? ({1'b0, bin_q} + step_ext) : ({1'b0, bin_q} - step_ext);

`ifdef GRAY_LOAD_EN
  assign load_bin = WIDTH'(gray2bin(MAX_W'(load_val)));
`else
  assign load_bin = load_val;
`endif

  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_bin;
    end else if (en) begin
      bin_nxt  = sum[WIDTH-1:0];
      wrap_nxt = sum[WIDTH];
    end
  end

  bin_to_gray_n #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: a directed table, hand-written corner sequences and random traffic.
// Two instances (W4/SM3 and W5/SM5) are checked every cycle against an arithmetic model.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [1:0] step0;
  logic [2:0] step1;
  logic [3:0] lv0, b0, g0;
  logic [4:0] lv1, b1, g1;
  logic       w0, w1;

  int total = 0;
  int bad   = 0;

  int unsigned mb0 = 0, mb1 = 0;
  bit          mw0 = 0, mw1 = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .STEP_MAX(3)) d0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .step(step0), .load(load),
    .load_val(lv0), .gray(g0), .bin(b0), .wrap(w0));

  gray_counter #(.WIDTH(5), .STEP_MAX(5)) d1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .step(step1), .load(load),
    .load_val(lv1), .gray(g1), .bin(b1), .wrap(w1));

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // The value the counter should hold after loading raw port value lval.
  function automatic int unsigned model_load(input int unsigned lval, input int w);
`ifdef GRAY_LOAD_EN
    for (int unsigned v = 0; v < (32'd1 << w); v++)
      if ((v ^ (v >> 1)) == lval) return v;
    return 0;
`else
    return lval;
`endif
  endfunction

  // The port value that loads binary value b.
  function automatic int unsigned lv(input int unsigned b);
`ifdef GRAY_LOAD_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic void mstep(input int w, input int unsigned sm, input int unsigned st,
                                input int unsigned lval, inout int unsigned b, inout bit wr);
    int unsigned s, m;
    m = 32'd1 << w;
    if (rst) begin
      b = 0; wr = 0;
    end else if (load) begin
      b = model_load(lval, w); wr = 0;
    end else if (en && st != 0) begin
      s = (st > sm) ? sm : st;
      if (up_dn) begin
        wr = (b + s) >= m;
        b  = (b + s) % m;
      end else begin
        wr = b < s;
        b  = (b + m - s) % m;
      end
    end else begin
      wr = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    mstep(4, 3, step0, lv0, mb0, mw0);
    mstep(5, 5, step1, lv1, mb1, mw1);
    #1;
    chk("d0_bin",  b0, mb0);
    chk("d0_gray", g0, mb0 ^ (mb0 >> 1));
    chk("d0_wrap", w0, mw0);
    chk("d1_bin",  b1, mb1);
    chk("d1_gray", g1, mb1 ^ (mb1 >> 1));
    chk("d1_wrap", w1, mw1);
  endtask

  task automatic drive(input bit r, input bit l, input bit e, input bit u,
                       input int unsigned st, input int unsigned lraw);
    rst = r; load = l; en = e; up_dn = u;
    step0 = 2'(st); step1 = 3'(st);
    lv0 = 4'(lraw); lv1 = 5'(lraw);
  endtask

  typedef struct {
    bit r, l, e, u;
    int unsigned st, lbin;
    int unsigned eb, eg;
    bit ew;
  } vec_t;

  vec_t vt[14];

  initial begin
    int unsigned gseq[16];
    int unsigned pg;
    int unsigned hb, hg;

    vt[0]  = '{1,1,1,1,3,5,  0, 0,0};
    vt[1]  = '{0,0,1,1,1,0,  1, 1,0};
    vt[2]  = '{0,0,1,1,2,0,  3, 2,0};
    vt[3]  = '{0,0,1,0,3,0,  0, 0,0};
    vt[4]  = '{0,0,1,0,1,0, 15, 8,1};
    vt[5]  = '{0,0,0,1,3,0, 15, 8,0};
    vt[6]  = '{0,1,1,1,3,14,14, 9,0};
    vt[7]  = '{0,0,1,1,3,0,  1, 1,1};
    vt[8]  = '{0,0,1,1,7,0,  4, 6,0};
    vt[9]  = '{0,0,1,0,2,0,  2, 3,0};
    vt[10] = '{0,0,1,1,0,0,  2, 3,0};
    vt[11] = '{0,1,0,0,0,9,  9,13,0};
    vt[12] = '{0,0,1,0,3,0,  6, 5,0};
    vt[13] = '{1,1,1,1,1,3,  0, 0,0};

    gseq = '{1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0};

    drive(1, 0, 0, 0, 0, 0);
    tick();

    // Directed table on the 4-bit instance.
    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].l, vt[i].e, vt[i].u, vt[i].st, lv(vt[i].lbin));
      tick();
      chk($sformatf("tbl%0d_bin", i),  b0, vt[i].eb);
      chk($sformatf("tbl%0d_gray", i), g0, vt[i].eg);
      chk($sformatf("tbl%0d_wrap", i), w0, vt[i].ew);
    end

    // Full up cycle at step 1: known Gray sequence, one bit per step, wrap only at 0.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    pg = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 1, 1, 0);
      tick();
      chk($sformatf("seq%0d_gray", i), g0, gseq[i]);
      chk($sformatf("seq%0d_wrap", i), w0, (i == 15) ? 1 : 0);
      chk($sformatf("seq%0d_onebit", i), $countones(4'(g0) ^ 4'(pg)), 1);
      pg = g0;
    end

    // Load together with en: load wins and wrap stays low.
    drive(0, 1, 1, 1, 1, 4'b0110);
    tick();
`ifdef GRAY_LOAD_EN
    chk("ld_bin", b0, 4); chk("ld_gray", g0, 6);
`else
    chk("ld_bin", b0, 6); chk("ld_gray", g0, 5);
`endif
    chk("ld_wrap", w0, 0);

    // step=0 with en=1 holds everything for 5 cycles.
    hb = b0; hg = g0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, i[0], 0, 0);
      tick();
      chk("hold_bin", b0, hb); chk("hold_gray", g0, hg); chk("hold_wrap", w0, 0);
    end

    // Saturation on the 5-bit instance: step 7 acts as 5.
    drive(0, 1, 0, 0, 0, lv(0));
    tick();
    drive(0, 0, 1, 1, 7, 0);
    tick();
    chk("sat_bin", b1, 5);
    drive(0, 0, 1, 0, 7, 0);
    tick();
    chk("sat_dn_bin", b1, 0);
    chk("sat_dn_wrap", w1, 0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 7), 1'($urandom), $urandom_range(0, 7),
            $urandom_range(0, 31));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter STEP_MAX, default 1, largest step magnitude accepted on step (legal range 1..2**(WIDTH-1)).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, count enable.
REQ-006 SHALL have port up_dn, input, 1: 1 counts up, 0 counts down.
REQ-007 SHALL have port step, input, $clog2(STEP_MAX+1), step magnitude; 0 means hold.
REQ-008 SHALL have port load, input, 1, load request.
REQ-009 SHALL have port load_val, input, WIDTH, load value.
REQ-010 SHALL have port gray, output, WIDTH, registered Gray-coded count.
REQ-011 SHALL have port bin, output, WIDTH, registered binary count.
REQ-012 SHALL have port wrap, output, 1, registered one-cycle pulse on modular wrap.

Function
REQ-013 SHALL hold the count internally in binary and keep gray equal to bin ^ (bin >> 1) on every cycle.
REQ-014 SHALL apply updates with priority rst > load > en.
REQ-015 SHALL, on load=1, set the count to the decoded load value on the next edge (1-cycle latency), ignore en, and deassert wrap.
REQ-016 SHALL, on en=1 and load=0, add step (up_dn=1) or subtract step (up_dn=0) modulo 2**WIDTH, with 1-cycle latency.
REQ-017 SHALL assert wrap for exactly the cycle after an update that crosses the modulus: up with bin+step >= 2**WIDTH, or down with bin < step.
REQ-018 SHALL hold bin, gray and state unchanged, with wrap=0, when en=0, or when step=0, and load=0.
REQ-019 SHALL treat step values above STEP_MAX as STEP_MAX (saturate).
REQ-020 SHALL change at most one gray bit per cycle whenever step=1 and no load occurs, including across wrap.
REQ-021 SHALL produce no combinational path from any input to any output.

Reset
REQ-022 SHALL, with rst=1 at a rising edge, set bin=0, gray=0, wrap=0 regardless of all other inputs.
REQ-023 SHALL abandon any load or count in the reset cycle; counting resumes from 0 on the first edge with rst=0.

Configuration
REQ-024 SHALL, with macro GRAY_LOAD_EN defined, interpret load_val as Gray code and convert it to binary (prefix XOR from MSB) before loading.
REQ-025 SHALL, without GRAY_LOAD_EN, load load_val directly as a binary value; the port list is identical in both builds.

Structure
REQ-026 SHALL place the bin-to-gray and gray-to-bin conversion functions, parameterised on width, in shared package gray_pkg.
REQ-027 SHALL instantiate one combinational sub-module, bin_to_gray_n (parameter WIDTH), to generate the next gray value from the next binary value.

Verification
REQ-028 SHALL cover: WIDTH=4, rst, then en=1 up_dn=1 step=1 for 16 cycles -> gray sequence 0,1,3,2,6,...,8,0; wrap=1 only on the cycle gray returns to 0.
REQ-029 SHALL cover: WIDTH=4, bin=0, en=1 up_dn=0 step=1 -> bin=15, gray=8, wrap=1 for one cycle.
REQ-030 SHALL cover: load=1 and en=1 together with load_val=4'b0110 -> with GRAY_LOAD_EN bin=4, gray=6; without it bin=6, gray=5; wrap=0 in both builds.
REQ-031 SHALL cover: STEP_MAX=3, bin=14, up, step=3 -> bin=1, wrap=1; then step=7 -> treated as 3, bin=4.
REQ-032 SHALL cover: rst asserted mid-count together with load=1 -> bin=0, gray=0, wrap=0 on the next edge.
REQ-033 SHALL cover: en=1 step=0 for 5 cycles -> outputs stable, wrap=0.
